// File: rtl/wordle_game_ctrl.sv
// Wordle game controller: guess buffer editing, two-pass scoring with duplicate-letter handling, win/lose tracking.
// Optional hard mode (green letters must be reused) is enabled by defining WORDLE_HARD_MODE_EN.
module wordle_game_ctrl #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6,
    parameter int LETTER_W    = 8,
    localparam int CW = $clog2(WORD_LEN + 1),
    localparam int GW = $clog2(MAX_GUESSES + 1),
    localparam int KW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic [WORD_LEN*LETTER_W-1:0] target_word,
    input  logic [LETTER_W-1:0]          letter_in,
    input  logic                         letter_valid,
    input  logic                         letter_del,
    input  logic                         submit,
    output logic [WORD_LEN*LETTER_W-1:0] guess_word,
    output logic [CW-1:0]                letter_count,
    output logic [GW-1:0]                guess_num,
    output logic [2*WORD_LEN-1:0]        feedback,
    output logic                         fb_valid,
    output logic                         reject,
    output logic                         win,
    output logic                         lose,
    output logic                         q_I,
    output logic                         q_Entry,
    output logic                         q_EvalG,
    output logic                         q_EvalY,
    output logic                         q_Result,
    output logic                         q_Done
);

    typedef enum logic [2:0] {
        S_I, S_ENTRY, S_EVALG, S_EVALY, S_RESULT, S_DONE
    } state_t;

    localparam logic [1:0] FB_GREY   = 2'b00;
    localparam logic [1:0] FB_YELLOW = 2'b01;
    localparam logic [1:0] FB_GREEN  = 2'b10;

    state_t state, nxt;

    logic [WORD_LEN-1:0][LETTER_W-1:0] guess_q, target_q;
    logic [WORD_LEN-1:0][1:0]          fb_q;
    logic [WORD_LEN-1:0]               consumed;
    logic [KW-1:0]                     k;

    logic [WORD_LEN-1:0] green_vec, hit;
    logic                found, all_green, last_k, full, hard_ok, submit_ok;

    assign guess_word = guess_q;
    assign feedback   = fb_q;
    assign fb_valid   = (state == S_RESULT);
    assign q_I        = (state == S_I);
    assign q_Entry    = (state == S_ENTRY);
    assign q_EvalG    = (state == S_EVALG);
    assign q_EvalY    = (state == S_EVALY);
    assign q_Result   = (state == S_RESULT);
    assign q_Done     = (state == S_DONE);

    assign full   = (letter_count == CW'(WORD_LEN));
    assign last_k = (k == KW'(WORD_LEN - 1));

    always_comb begin
        green_vec = '0;
        all_green = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            green_vec[i] = (guess_q[i] == target_q[i]);
            if (fb_q[i] != FB_GREEN) all_green = 1'b0;
        end
    end

    // First unconsumed target letter matching guess[k]; lowest index wins.
    always_comb begin
        found = 1'b0;
        hit   = '0;
        for (int j = 0; j < WORD_LEN; j++) begin
            if (!found && !consumed[j] && target_q[j] == guess_q[k]) begin
                found  = 1'b1;
                hit[j] = 1'b1;
            end
        end
    end

`ifdef WORDLE_HARD_MODE_EN
    logic [WORD_LEN-1:0]               green_lock;
    logic [WORD_LEN-1:0][LETTER_W-1:0] lock_letter;

    always_comb begin
        hard_ok = 1'b1;
        for (int i = 0; i < WORD_LEN; i++)
            if (green_lock[i] && guess_q[i] != lock_letter[i]) hard_ok = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            green_lock  <= '0;
            lock_letter <= '0;
        end else if (state == S_I && Start) begin
            green_lock  <= '0;
        end else if (state == S_EVALG) begin
            for (int i = 0; i < WORD_LEN; i++)
                if (green_vec[i]) begin
                    green_lock[i]  <= 1'b1;
                    lock_letter[i] <= guess_q[i];
                end
        end
    end
`else
    assign hard_ok = 1'b1;
`endif

    assign submit_ok = submit && full && !letter_valid && !letter_del && hard_ok;

    always_ff @(posedge Clk) begin
        if (reset) state <= S_I;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_I:      if (Start) nxt = S_ENTRY;
            S_ENTRY:  if (submit_ok) nxt = S_EVALG;
            S_EVALG:  nxt = S_EVALY;
            S_EVALY:  if (last_k) nxt = S_RESULT;
            S_RESULT: if (Ack) nxt = (win || lose) ? S_DONE : S_ENTRY;
            S_DONE:   if (Ack) nxt = S_I;
            default:  nxt = S_I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            guess_q      <= '0;
            target_q     <= '0;
            fb_q         <= '0;
            consumed     <= '0;
            k            <= '0;
            letter_count <= '0;
            guess_num    <= '0;
            reject       <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                S_I: if (Start) begin
                    target_q     <= target_word;
                    guess_q      <= '0;
                    fb_q         <= '0;
                    letter_count <= '0;
                    guess_num    <= '0;
                    win          <= 1'b0;
                    lose         <= 1'b0;
                end
                S_ENTRY: begin
                    if (letter_del) begin
                        if (letter_count != '0) letter_count <= letter_count - 1'b1;
                    end else if (letter_valid && !full) begin
                        guess_q[letter_count] <= letter_in;
                        letter_count          <= letter_count + 1'b1;
                    end
                    reject <= submit && !submit_ok;
                end
                S_EVALG: begin
                    for (int i = 0; i < WORD_LEN; i++)
                        fb_q[i] <= green_vec[i] ? FB_GREEN : FB_GREY;
                    consumed <= green_vec;
                    k        <= '0;
                end
                S_EVALY: begin
                    if (fb_q[k] != FB_GREEN && found) begin
                        fb_q[k]  <= FB_YELLOW;
                        consumed <= consumed | hit;
                    end
                    k <= k + 1'b1;
                    // Yellow marks never touch green slots, so all_green is already final here.
                    if (last_k) begin
                        guess_num <= guess_num + 1'b1;
                        if (all_green)
                            win <= 1'b1;
                        else if ((guess_num + GW'(1)) == GW'(MAX_GUESSES))
                            lose <= 1'b1;
                    end
                end
                S_RESULT: if (Ack && !(win || lose)) letter_count <= '0;
                S_DONE: if (Ack) begin
                    win  <= 1'b0;
                    lose <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
